// File: rtl/csa_serial_group_adder.sv
// csa_serial_group_adder: serial carry-skip adder, one GROUP-bit slice per cycle; SKIP_STATS_EN adds skip_cnt
module csa_serial_group_adder #(
  parameter int WIDTH = 16,
  parameter int GROUP = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SKIP_STATS_EN
  ,
  output logic [$clog2(WIDTH/GROUP+1)-1:0] skip_cnt
`endif
);
  localparam int N = WIDTH / GROUP;
  localparam int KW = N > 1 ? $clog2(N) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, nxt;
  logic [WIDTH-1:0] a_r, b_r;
  logic carry, gco, last;
  logic [KW-1:0] k;
  logic [GROUP-1:0] p, g, s;
  assign p = a_r[k*GROUP +: GROUP] ^ b_r[k*GROUP +: GROUP];
  assign g = a_r[k*GROUP +: GROUP] & b_r[k*GROUP +: GROUP];
  assign last = k == KW'(N - 1);
  assign in_ready = state == IDLE;
  assign out_valid = state == DONE;
  // a fully propagating group passes its carry-in straight through
  always_comb begin : ripple
    logic c;
    c = carry;
    s = '0;
    for (int i = 0; i < GROUP; i++) begin
      s[i] = p[i] ^ c;
      c = g[i] | (p[i] & c);
    end
    gco = &p ? carry : c;
  end
  always_comb begin
    nxt = state;
    if (state == IDLE && in_valid) nxt = RUN;
    else if (state == RUN && last) nxt = DONE;
    else if (state == DONE && out_ready) nxt = IDLE;
  end
  always_ff @(posedge clk) state <= rst ? IDLE : nxt;
  always_ff @(posedge clk) begin
    if (rst) begin
      a_r <= '0;
      b_r <= '0;
      carry <= 1'b0;
      k <= '0;
      sum <= '0;
      cout <= 1'b0;
    end else if (state == IDLE && in_valid) begin
      a_r <= a;
      b_r <= b;
      carry <= cin;
      k <= '0;
    end else if (state == RUN) begin
      sum[k*GROUP +: GROUP] <= s;
      carry <= gco;
      k <= last ? '0 : k + KW'(1);
      if (last) cout <= gco;
    end
  end
`ifdef SKIP_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) skip_cnt <= '0;
    else if (state == IDLE && in_valid) skip_cnt <= '0;
    else if (state == RUN && &p) skip_cnt <= skip_cnt + 1'b1;
  end
`endif
endmodule

// File: tb/tb_csa_serial_group_adder.sv
// tb_csa_serial_group_adder: directed + random checks against an arithmetic reference model
module tb_csa_serial_group_adder;
  localparam int W = 16, G = 4, N = W / G;
  logic clk = 0, rst = 1, in_valid = 0, cin = 0, out_ready = 1;
  logic in_ready, out_valid, cout;
  logic [W-1:0] a = 0, b = 0, sum;
  int tests = 0, fails = 0, cyc = 0;
`ifdef SKIP_STATS_EN
  logic [$clog2(N+1)-1:0] skip_cnt;
`endif
  csa_serial_group_adder #(.WIDTH(W), .GROUP(G)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b), .cin(cin),
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout)
`ifdef SKIP_STATS_EN
    , .skip_cnt(skip_cnt)
`endif
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W:0] ref_add(input logic [W-1:0] x, y, input logic c);
    return {1'b0, x} + {1'b0, y} + (W+1)'(c);
  endfunction

  function automatic int ref_skips(input logic [W-1:0] x, y);
    int n = 0;
    for (int i = 0; i < N; i++) if ((((x ^ y) >> (i * G)) & 16'hF) == 16'hF) n++;
    return n;
  endfunction

  task automatic check_result(input string tag, input logic [W-1:0] x, y, input logic c);
    logic [W:0] r = ref_add(x, y, c);
    chk({tag, ".sum"}, 32'(sum), 32'(r[W-1:0]));
    chk({tag, ".cout"}, 32'(cout), 32'(r[W]));
`ifdef SKIP_STATS_EN
    chk({tag, ".skip"}, 32'(skip_cnt), 32'(ref_skips(x, y)));
`endif
  endtask

  // called at a negedge with the block expected in IDLE
  task automatic op(input string tag, input logic [W-1:0] x, y, input logic c, input int stall);
    int lat;
    chk({tag, ".in_ready"}, 32'(in_ready), 1);
    in_valid = 1; a = x; b = y; cin = c; out_ready = 1;
    @(negedge clk);
    in_valid = $urandom; a = $urandom; b = $urandom; cin = $urandom;
    chk({tag, ".busy"}, 32'(in_ready), 0);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
      if (!out_valid) begin in_valid = $urandom; a = $urandom; b = $urandom; end
    end
    chk({tag, ".latency"}, 32'(lat), N);
    in_valid = 0;
    check_result(tag, x, y, c);
    if (stall > 0) begin
      out_ready = 0;
      for (int i = 0; i < stall; i++) begin
        @(negedge clk);
        chk({tag, ".hold_valid"}, 32'(out_valid), 1);
        chk({tag, ".hold_ready"}, 32'(in_ready), 0);
        check_result({tag, ".hold"}, x, y, c);
      end
      out_ready = 1;
    end
    @(negedge clk);
    chk({tag, ".idle_valid"}, 32'(out_valid), 0);
    chk({tag, ".idle_ready"}, 32'(in_ready), 1);
  endtask

  logic [W-1:0] pa[3] = '{16'h0001, 16'h8000, 16'h00F0};
  logic [W-1:0] pb[3] = '{16'h0001, 16'h8000, 16'h0F10};
  int acc[3];

  initial begin
    int n;
    repeat (3) @(negedge clk);
    chk("rst.in_ready", 32'(in_ready), 1);
    chk("rst.out_valid", 32'(out_valid), 0);
    chk("rst.sum", 32'(sum), 0);
    chk("rst.cout", 32'(cout), 0);
`ifdef SKIP_STATS_EN
    chk("rst.skip", 32'(skip_cnt), 0);
`endif
    rst = 0;
    op("ex030", 16'h1234, 16'h4321, 0, 0);
    op("ex031", 16'hFFFF, 16'h0000, 1, 0);
    op("ex032", 16'hFFFF, 16'h0001, 0, 3);
    // reset while group 2 is pending
    in_valid = 1; a = $urandom; b = $urandom; cin = $urandom;
    @(negedge clk);
    in_valid = 0;
    repeat (2) @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("midrst.in_ready", 32'(in_ready), 1);
    chk("midrst.out_valid", 32'(out_valid), 0);
    chk("midrst.sum", 32'(sum), 0);
    n = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid) n++;
    end
    chk("midrst.no_pulse", 32'(n), 0);
    op("ex033", 16'h0001, 16'h0001, 0, 0);
    // back-to-back with in_valid held high
    in_valid = 1; out_ready = 1;
    for (int j = 0; j < 3; j++) begin
      n = 0;
      while (!in_ready && n < 20) begin @(negedge clk); n++; end
      chk("b2b.ready_wait", 32'(n < 20), 1);
      a = pa[j]; b = pb[j]; cin = 0;
      @(negedge clk);
      acc[j] = cyc;
      n = 0;
      while (!out_valid && n < 20) begin @(negedge clk); n++; end
      chk("b2b.valid_wait", 32'(n < 20), 1);
      chk("b2b.sum", 32'(sum), 32'(ref_add(pa[j], pb[j], 0) & 17'hFFFF));
      chk("b2b.cout", 32'(cout), 32'(ref_add(pa[j], pb[j], 0) >> W));
    end
    in_valid = 0;
    @(negedge clk);
    // accept edges are N+2 apart: N RUN, one DONE, one IDLE cycle
    chk("b2b.gap01", 32'(acc[1] - acc[0] - 1), 5);
    chk("b2b.gap12", 32'(acc[2] - acc[1] - 1), 5);
    for (int i = 0; i < 24; i++) begin
      logic [W-1:0] x, y;
      x = $urandom; y = $urandom;
      if (i % 4 == 0) y = ~x ^ 16'($urandom_range(0, 15) << (4 * $urandom_range(0, 3)));
      op("rand", x, y, 1'($urandom), int'($urandom_range(0, 3)));
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
